// File: rtl/cceip_inbound_framer.sv
// CCEIP inbound framer: programmable prefix/suffix command words
// wrapped around one payload stream, with EoT tuser and byte tstrb.
module cceip_inbound_framer #(
    parameter int DATA_W       = 64,
    parameter int PREFIX_DEPTH = 8,
    parameter int SUFFIX_DEPTH = 4,
    parameter int SIZE_W       = 64,
    localparam int BYTES  = DATA_W / 8,
    localparam int PL_W   = $clog2(PREFIX_DEPTH) + 1,
    localparam int SL_W   = $clog2(SUFFIX_DEPTH) + 1,
    localparam int MAXD   = (PREFIX_DEPTH > SUFFIX_DEPTH) ? PREFIX_DEPTH : SUFFIX_DEPTH,
    localparam int ADDR_W = (MAXD > 1) ? $clog2(MAXD) : 1
) (
    input  logic              ap_clk,
    input  logic              areset,
    input  logic              start,
    output logic              done,
    output logic              busy,
    input  logic [SIZE_W-1:0] input_data_size,
    input  logic [PL_W-1:0]   prefix_len,
    input  logic [SL_W-1:0]   suffix_len,
    input  logic              cfg_we,
    input  logic              cfg_sel,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [1:0]        cfg_tuser,
    input  logic [DATA_W-1:0] cfg_tdata,
    output logic              err_early_last,
    input  logic              mm_s_axis_tvalid,
    output logic              mm_s_axis_tready,
    input  logic              mm_s_axis_tlast,
    input  logic [DATA_W-1:0] mm_s_axis_tdata,
    output logic              cceip_m_axis_tvalid,
    input  logic              cceip_m_axis_tready,
    output logic              cceip_m_axis_tlast,
    output logic [BYTES-1:0]  cceip_m_axis_tstrb,
    output logic [7:0]        cceip_m_axis_tuser,
    output logic              cceip_m_axis_tid,
    output logic [DATA_W-1:0] cceip_m_axis_tdata
);

    localparam int LEN_W = $clog2(MAXD) + 1;
    localparam logic [LEN_W-1:0]  P_DEPTH = LEN_W'(PREFIX_DEPTH);
    localparam logic [LEN_W-1:0]  S_DEPTH = LEN_W'(SUFFIX_DEPTH);
    localparam logic [LEN_W-1:0]  ONE_L   = LEN_W'(1);
    localparam logic [SIZE_W-1:0] ONE_S   = SIZE_W'(1);
    localparam logic [SIZE_W-1:0] BYTES_S = SIZE_W'(BYTES);

    typedef enum logic [2:0] {IDLE, PREFIX, DATA, SUFFIX, DONE} state_t;

    function automatic state_t after_prefix(input logic data_nz, input logic sfx_nz);
        if (data_nz) return DATA;
        else if (sfx_nz) return SUFFIX;
        else return DONE;
    endfunction

    state_t state, state_n;

    logic [LEN_W-1:0]  ptr, plen, slen;
    logic [SIZE_W-1:0] beat, n_beats;
    logic [BYTES-1:0]  last_strb;
    logic [1:0]        code;

    logic [DATA_W-1:0] pt_data [MAXD];
    logic [1:0]        pt_user [MAXD];
    logic [DATA_W-1:0] st_data [MAXD];
    logic [1:0]        st_user [MAXD];

    logic [LEN_W-1:0]  plen_in, slen_in;
    logic [SIZE_W-1:0] resid_in, n_in;
    logic [BYTES-1:0]  strb_in;
    logic [ADDR_W-1:0] idx;
    logic              last_p, last_s, last_beat, final_beat;

    assign plen_in = (LEN_W'(prefix_len) > P_DEPTH) ? P_DEPTH : LEN_W'(prefix_len);
    assign slen_in = (LEN_W'(suffix_len) > S_DEPTH) ? S_DEPTH : LEN_W'(suffix_len);

    // Quotient plus one for a partial beat cannot overflow SIZE_W.
    assign resid_in = input_data_size % BYTES_S;
    assign n_in     = input_data_size / BYTES_S + SIZE_W'(resid_in != '0);

    always_comb begin
        strb_in = '0;
        for (int i = 0; i < BYTES; i++)
            strb_in[i] = (resid_in == '0) || (SIZE_W'(i) < resid_in);
    end

    assign idx        = ptr[ADDR_W-1:0];
    assign last_p     = (ptr == plen - ONE_L);
    assign last_s     = (ptr == slen - ONE_L);
    assign last_beat  = (beat == n_beats - ONE_S);
    assign final_beat = last_beat || mm_s_axis_tlast;

    assign busy               = (state != IDLE);
    assign cceip_m_axis_tuser = {6'b0, code};
    assign cceip_m_axis_tid   = 1'b0;

    always_comb begin
        state_n             = state;
        cceip_m_axis_tvalid = 1'b0;
        cceip_m_axis_tlast  = 1'b0;
        cceip_m_axis_tstrb  = '1;
        cceip_m_axis_tdata  = '0;
        code                = 2'd0;
        mm_s_axis_tready    = 1'b0;
        done                = 1'b0;
        unique case (state)
            IDLE: begin
                if (start)
                    state_n = (plen_in != '0) ? PREFIX
                            : after_prefix(input_data_size != '0, slen_in != '0);
            end
            PREFIX: begin
                cceip_m_axis_tvalid = 1'b1;
                cceip_m_axis_tdata  = pt_data[idx];
                code                = pt_user[idx];
                cceip_m_axis_tlast  = last_p && (n_beats == '0) && (slen == '0);
                if (cceip_m_axis_tready && last_p)
                    state_n = after_prefix(n_beats != '0, slen != '0);
            end
            DATA: begin
                cceip_m_axis_tvalid = mm_s_axis_tvalid;
                mm_s_axis_tready    = cceip_m_axis_tready;
                cceip_m_axis_tdata  = mm_s_axis_tdata;
                // An early tlast ends the payload with a full-width beat.
                if (last_beat) begin
                    code               = 2'd2;
                    cceip_m_axis_tstrb = last_strb;
                end else if (mm_s_axis_tlast) begin
                    code = 2'd2;
                end
                cceip_m_axis_tlast = final_beat && (slen == '0);
                if (mm_s_axis_tvalid && cceip_m_axis_tready && final_beat)
                    state_n = (slen != '0) ? SUFFIX : DONE;
            end
            SUFFIX: begin
                cceip_m_axis_tvalid = 1'b1;
                cceip_m_axis_tdata  = st_data[idx];
                code                = st_user[idx];
                cceip_m_axis_tlast  = last_s;
                if (cceip_m_axis_tready && last_s)
                    state_n = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            state          <= IDLE;
            ptr            <= '0;
            plen           <= '0;
            slen           <= '0;
            beat           <= '0;
            n_beats        <= '0;
            last_strb      <= '1;
            err_early_last <= 1'b0;
            for (int i = 0; i < MAXD; i++) begin
                pt_data[i] <= '0;
                pt_user[i] <= '0;
                st_data[i] <= '0;
                st_user[i] <= '0;
            end
        end else begin
            state <= state_n;
            unique case (state)
                IDLE: begin
                    if (cfg_we && !cfg_sel && (LEN_W'(cfg_addr) < P_DEPTH)) begin
                        pt_data[cfg_addr] <= cfg_tdata;
                        pt_user[cfg_addr] <= cfg_tuser;
                    end
                    if (cfg_we && cfg_sel && (LEN_W'(cfg_addr) < S_DEPTH)) begin
                        st_data[cfg_addr] <= cfg_tdata;
                        st_user[cfg_addr] <= cfg_tuser;
                    end
                    if (start) begin
                        plen           <= plen_in;
                        slen           <= slen_in;
                        n_beats        <= n_in;
                        last_strb      <= strb_in;
                        ptr            <= '0;
                        beat           <= '0;
                        err_early_last <= 1'b0;
                    end
                end
                PREFIX: begin
                    if (cceip_m_axis_tready)
                        ptr <= last_p ? '0 : ptr + ONE_L;
                end
                DATA: begin
                    if (mm_s_axis_tvalid && cceip_m_axis_tready) begin
                        beat <= beat + ONE_S;
                        if (mm_s_axis_tlast && !last_beat)
                            err_early_last <= 1'b1;
                    end
                end
                SUFFIX: begin
                    if (cceip_m_axis_tready)
                        ptr <= ptr + ONE_L;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cceip_inbound_framer.sv
// Scoreboard bench for cceip_inbound_framer (DATA_W=64): directed frames
// with a queued expected-beat list checked by an independent monitor.
module tb_cceip_inbound_framer;

    logic        ap_clk = 1'b0;
    logic        areset;
    logic        start;
    logic        done;
    logic        busy;
    logic [63:0] input_data_size;
    logic [3:0]  prefix_len;
    logic [2:0]  suffix_len;
    logic        cfg_we;
    logic        cfg_sel;
    logic [2:0]  cfg_addr;
    logic [1:0]  cfg_tuser;
    logic [63:0] cfg_tdata;
    logic        err_early_last;
    logic        mm_s_axis_tvalid;
    logic        mm_s_axis_tready;
    logic        mm_s_axis_tlast;
    logic [63:0] mm_s_axis_tdata;
    logic        cceip_m_axis_tvalid;
    logic        cceip_m_axis_tready;
    logic        cceip_m_axis_tlast;
    logic [7:0]  cceip_m_axis_tstrb;
    logic [7:0]  cceip_m_axis_tuser;
    logic        cceip_m_axis_tid;
    logic [63:0] cceip_m_axis_tdata;

    always #5 ap_clk = ~ap_clk;

    cceip_inbound_framer dut (
        .ap_clk              (ap_clk),
        .areset              (areset),
        .start               (start),
        .done                (done),
        .busy                (busy),
        .input_data_size     (input_data_size),
        .prefix_len          (prefix_len),
        .suffix_len          (suffix_len),
        .cfg_we              (cfg_we),
        .cfg_sel             (cfg_sel),
        .cfg_addr            (cfg_addr),
        .cfg_tuser           (cfg_tuser),
        .cfg_tdata           (cfg_tdata),
        .err_early_last      (err_early_last),
        .mm_s_axis_tvalid    (mm_s_axis_tvalid),
        .mm_s_axis_tready    (mm_s_axis_tready),
        .mm_s_axis_tlast     (mm_s_axis_tlast),
        .mm_s_axis_tdata     (mm_s_axis_tdata),
        .cceip_m_axis_tvalid (cceip_m_axis_tvalid),
        .cceip_m_axis_tready (cceip_m_axis_tready),
        .cceip_m_axis_tlast  (cceip_m_axis_tlast),
        .cceip_m_axis_tstrb  (cceip_m_axis_tstrb),
        .cceip_m_axis_tuser  (cceip_m_axis_tuser),
        .cceip_m_axis_tid    (cceip_m_axis_tid),
        .cceip_m_axis_tdata  (cceip_m_axis_tdata)
    );

    typedef struct packed {
        logic [63:0] d;
        logic        l;
    } mm_t;

    localparam logic [63:0] WA  = 64'hA1A1_0000_1111_00A1;
    localparam logic [63:0] WB  = 64'hB2B2_0000_2222_00B2;
    localparam logic [63:0] WC  = 64'hC3C3_0000_3333_00C3;
    localparam logic [63:0] WS0 = 64'h5050_FFFF_0000_0050;
    localparam logic [63:0] WS1 = 64'h5151_FFFF_0000_0051;
    localparam logic [63:0] WS2 = 64'h5252_FFFF_0000_0052;
    localparam logic [63:0] WS3 = 64'h5353_FFFF_0000_0053;

    mm_t         mm_q [$];
    logic [80:0] exp_q [$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    int          rdy_prob = 100;
    int          mm_prob = 100;
    bit          mm_hs = 1'b0;
    bit          stall_prev = 1'b0;
    bit          done_next = 1'b0;
    logic [63:0] prev_data;
    logic [80:0] act_beat;
    logic [80:0] exp_beat;
    bit          keep;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pd(input int f, input int i);
        return {16'(f), 16'hC0DE, 32'(i)};
    endfunction

    task automatic px(input logic [63:0] d, input logic [1:0] u, input logic l);
        exp_q.push_back({d, 6'b0, u, 8'hFF, l});
    endtask

    task automatic dx(input logic [63:0] d, input logic [7:0] u, input logic [7:0] s,
                      input logic l);
        exp_q.push_back({d, u, s, l});
    endtask

    task automatic mmx(input logic [63:0] d, input logic l);
        mm_t m;
        m.d = d;
        m.l = l;
        mm_q.push_back(m);
    endtask

    // Monitor: all outputs sampled on the falling edge.
    initial begin
        forever begin
            @(negedge ap_clk);
            if (areset) begin
                stall_prev = 1'b0;
                done_next  = 1'b0;
                mm_hs      = 1'b0;
            end else begin
                if (done_next) begin
                    chk("done_after_tlast", 128'(done), 128'(1));
                    done_next = 1'b0;
                end
                if (stall_prev) begin
                    chk("hold_valid", 128'(cceip_m_axis_tvalid), 128'(1));
                    chk("hold_data", 128'(cceip_m_axis_tdata), 128'(prev_data));
                end
                if (cceip_m_axis_tvalid && cceip_m_axis_tready) begin
                    act_beat = {cceip_m_axis_tdata, cceip_m_axis_tuser,
                                cceip_m_axis_tstrb, cceip_m_axis_tlast};
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got %0h, none expected", act_beat);
                    end else begin
                        exp_beat = exp_q.pop_front();
                        chk("out_beat", 128'(act_beat), 128'(exp_beat));
                    end
                    if (cceip_m_axis_tlast)
                        done_next = 1'b1;
                end
                if (done)
                    done_cnt++;
                stall_prev = cceip_m_axis_tvalid && !cceip_m_axis_tready;
                prev_data  = cceip_m_axis_tdata;
                mm_hs      = mm_s_axis_tvalid && mm_s_axis_tready;
            end
        end
    end

    // Payload source and downstream ready, both updated just after the edge.
    initial begin
        mm_s_axis_tvalid    = 1'b0;
        mm_s_axis_tlast     = 1'b0;
        mm_s_axis_tdata     = '0;
        cceip_m_axis_tready = 1'b0;
        forever begin
            @(posedge ap_clk);
            #1;
            keep = mm_s_axis_tvalid && !mm_hs;
            if (mm_hs && mm_q.size() > 0)
                void'(mm_q.pop_front());
            if (mm_q.size() > 0 && (keep || int'($urandom_range(99, 0)) < mm_prob)) begin
                mm_s_axis_tvalid = 1'b1;
                mm_s_axis_tdata  = mm_q[0].d;
                mm_s_axis_tlast  = mm_q[0].l;
            end else begin
                mm_s_axis_tvalid = 1'b0;
            end
            cceip_m_axis_tready = int'($urandom_range(99, 0)) < rdy_prob;
        end
    end

    task automatic cfg_write(input logic sel, input int addr, input logic [1:0] u,
                             input logic [63:0] d);
        cfg_we    = 1'b1;
        cfg_sel   = sel;
        cfg_addr  = 3'(addr);
        cfg_tuser = u;
        cfg_tdata = d;
        @(posedge ap_clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic start_frame(input int pl, input int sz, input int sl);
        prefix_len      = 4'(pl);
        suffix_len      = 3'(sl);
        input_data_size = 64'(sz);
        start           = 1'b1;
        @(posedge ap_clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int  c0;
        bit  got;
        c0  = done_cnt;
        got = 1'b0;
        for (int k = 0; k < 3000 && !got; k++) begin
            @(posedge ap_clk);
            #1;
            if (done_cnt != c0)
                got = 1'b1;
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: no done within 3000 cycles, expected one", name);
        end
        repeat (3) @(posedge ap_clk);
        #1;
        chk({name, "_done_once"}, 128'(done_cnt - c0), 128'(1));
        chk({name, "_exp_empty"}, 128'(exp_q.size()), 128'(0));
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        areset          = 1'b1;
        start           = 1'b0;
        cfg_we          = 1'b0;
        cfg_sel         = 1'b0;
        cfg_addr        = '0;
        cfg_tuser       = '0;
        cfg_tdata       = '0;
        prefix_len      = '0;
        suffix_len      = '0;
        input_data_size = '0;
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        chk("rst_tvalid", 128'(cceip_m_axis_tvalid), 128'(0));
        chk("rst_tstrb", 128'(cceip_m_axis_tstrb), 128'(8'hFF));
        chk("rst_tdata", 128'(cceip_m_axis_tdata), 128'(0));
        chk("rst_busy_done", 128'({busy, done, err_early_last}), 128'(0));
        chk("rst_mm_tready", 128'(mm_s_axis_tready), 128'(0));
        @(posedge ap_clk);
        #1;
        areset = 1'b0;

        cfg_write(1'b0, 0, 2'd1, WA);
        cfg_write(1'b0, 1, 2'd3, WB);
        cfg_write(1'b0, 2, 2'd0, WC);
        cfg_write(1'b1, 0, 2'd1, WS0);
        cfg_write(1'b1, 1, 2'd3, WS1);
        cfg_write(1'b1, 2, 2'd2, WS2);
        cfg_write(1'b1, 3, 2'd0, WS3);

        // 20 bytes: 3 beats, final residue 4 bytes
        px(WA, 2'd1, 1'b0);
        px(WB, 2'd3, 1'b0);
        dx(pd(1, 0), 8'h00, 8'hFF, 1'b0);
        dx(pd(1, 1), 8'h00, 8'hFF, 1'b0);
        dx(pd(1, 2), 8'h02, 8'h0F, 1'b0);
        px(WS0, 2'd1, 1'b1);
        for (int i = 0; i < 3; i++) mmx(pd(1, i), i == 2);
        start_frame(2, 20, 1);
        wait_done("size20");
        chk("size20_err", 128'(err_early_last), 128'(0));

        // 16 bytes exactly, extra beat offered must stay unconsumed
        dx(pd(2, 0), 8'h00, 8'hFF, 1'b0);
        dx(pd(2, 1), 8'h02, 8'hFF, 1'b1);
        for (int i = 0; i < 3; i++) mmx(pd(2, i), 1'b0);
        start_frame(0, 16, 0);
        wait_done("size16");
        chk("size16_extra_beat_left", 128'(mm_q.size()), 128'(1));
        mm_q.delete();

        // 1000 bytes under random backpressure on both sides
        rdy_prob = 60;
        mm_prob  = 70;
        px(WA, 2'd1, 1'b0);
        px(WB, 2'd3, 1'b0);
        for (int i = 0; i < 125; i++) begin
            dx(pd(3, i), (i == 124) ? 8'h02 : 8'h00, 8'hFF, 1'b0);
            mmx(pd(3, i), i == 124);
        end
        px(WS0, 2'd1, 1'b0);
        px(WS1, 2'd3, 1'b1);
        start_frame(2, 1000, 2);
        wait_done("size1000");
        chk("size1000_all_consumed", 128'(mm_q.size()), 128'(0));
        rdy_prob = 100;
        mm_prob  = 100;

        // early tlast on second of five beats
        px(WA, 2'd1, 1'b0);
        dx(pd(4, 0), 8'h00, 8'hFF, 1'b0);
        dx(pd(4, 1), 8'h02, 8'hFF, 1'b0);
        px(WS0, 2'd1, 1'b1);
        mmx(pd(4, 0), 1'b0);
        mmx(pd(4, 1), 1'b1);
        start_frame(1, 40, 1);
        wait_done("early");
        chk("early_err_set", 128'(err_early_last), 128'(1));

        // prefix-only frame; start clears the sticky error
        px(WA, 2'd1, 1'b0);
        px(WB, 2'd3, 1'b0);
        px(WC, 2'd0, 1'b1);
        mmx(pd(5, 0), 1'b0);
        start_frame(3, 0, 0);
        chk("err_cleared_on_start", 128'(err_early_last), 128'(0));
        wait_done("prefix_only");
        chk("prefix_only_no_mm", 128'(mm_q.size()), 128'(1));
        mm_q.delete();

        // empty frame: done the cycle after start
        start = 1'b1;
        prefix_len      = '0;
        suffix_len      = '0;
        input_data_size = '0;
        @(posedge ap_clk);
        #1;
        start = 1'b0;
        @(negedge ap_clk);
        chk("empty_done_high", 128'({done, busy}), 128'(2'b11));
        @(negedge ap_clk);
        chk("empty_done_low", 128'({done, busy}), 128'(2'b00));
        @(posedge ap_clk);
        #1;

        // 9 bytes (residue 1) and suffix_len 7 clamped to 4
        dx(pd(7, 0), 8'h00, 8'hFF, 1'b0);
        dx(pd(7, 1), 8'h02, 8'h01, 1'b0);
        px(WS0, 2'd1, 1'b0);
        px(WS1, 2'd3, 1'b0);
        px(WS2, 2'd2, 1'b0);
        px(WS3, 2'd0, 1'b1);
        mmx(pd(7, 0), 1'b0);
        mmx(pd(7, 1), 1'b0);
        start_frame(0, 9, 7);
        wait_done("clamp");

        // table write while PREFIX is stalled has no effect
        rdy_prob = 0;
        @(posedge ap_clk);
        #1;
        px(WA, 2'd1, 1'b0);
        px(WB, 2'd3, 1'b1);
        start_frame(2, 0, 0);
        cfg_write(1'b0, 0, 2'd2, 64'hDEAD_BEEF_DEAD_BEEF);
        cfg_write(1'b1, 0, 2'd2, 64'hDEAD_BEEF_DEAD_BEEF);
        rdy_prob = 100;
        wait_done("cfg_busy");
        px(WA, 2'd1, 1'b0);
        px(WS0, 2'd1, 1'b1);
        start_frame(1, 0, 1);
        wait_done("cfg_kept");

        // reset in the middle of DATA
        mm_prob = 0;
        start_frame(0, 80, 1);
        @(negedge ap_clk);
        chk("mid_data_busy", 128'({busy, mm_s_axis_tready}), 128'(2'b11));
        @(posedge ap_clk);
        #1;
        areset = 1'b1;
        @(posedge ap_clk);
        @(negedge ap_clk);
        chk("areset_busy", 128'({busy, done}), 128'(0));
        chk("areset_tvalid", 128'({cceip_m_axis_tvalid, cceip_m_axis_tlast}), 128'(0));
        chk("areset_tstrb", 128'(cceip_m_axis_tstrb), 128'(8'hFF));
        chk("areset_tuser", 128'(cceip_m_axis_tuser), 128'(0));
        chk("areset_mm_tready", 128'(mm_s_axis_tready), 128'(0));
        @(posedge ap_clk);
        #1;
        areset  = 1'b0;
        mm_prob = 100;

        // tables were cleared by reset
        dx(64'h0, 8'h00, 8'hFF, 1'b1);
        start_frame(1, 0, 0);
        wait_done("cleared_table");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
